// File: rtl/box_plotter.sv
// box_plotter: steps a BOX_W x BOX_H rectangle in raster order as a stream of registered plot pixels.
// Define BOX_PLOTTER_CLIP_EN to suppress plot for pixels beyond SCREEN_W/SCREEN_H.
module box_plotter #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int C_W       = 3,
  parameter int BOX_W     = 4,
  parameter int BOX_H     = 4,
  parameter int BG_COLOUR = 0,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic           erase,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [C_W-1:0] colour_in,
  input  logic           pix_ready,
  output logic           busy,
  output logic           done,
  output logic           plot,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [C_W-1:0] colour_out
);
  localparam int CW = BOX_W > 1 ? $clog2(BOX_W) : 1;
  localparam int RW = BOX_H > 1 ? $clog2(BOX_H) : 1;
`ifdef BOX_PLOTTER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;
  state_t state_q, state_d;
  logic [X_W-1:0] bx_q, bx_d, x_q, x_d;
  logic [Y_W-1:0] by_q, by_d, y_q, y_d;
  logic [C_W-1:0] colour_q, colour_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic [X_W:0]   sx;
  logic [Y_W:0]   sy;
  logic           col_end, last;
  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    colour_d = colour_q;
    col_d    = col_q;
    row_d    = row_q;
    col_end  = col_q == CW'(BOX_W - 1);
    last     = col_end && row_q == RW'(BOX_H - 1);
    case (state_q)
      IDLE: if (start) begin
        state_d  = PLOT;
        bx_d     = x_in;
        by_d     = y_in;
        colour_d = erase ? C_W'(BG_COLOUR) : colour_in;
        col_d    = '0;
        row_d    = '0;
      end
      PLOT: if (pix_ready) begin
        state_d = last ? DONE : PLOT;
        col_d   = col_end ? '0 : col_q + 1'b1;
        row_d   = last ? '0 : col_end ? row_q + 1'b1 : row_q;
      end
      default: state_d = IDLE;
    endcase
    // one extra bit keeps the unwrapped sum so off-screen pixels can be recognised
    sx     = {1'b0, bx_d} + (X_W+1)'(col_d);
    sy     = {1'b0, by_d} + (Y_W+1)'(row_d);
    x_d    = sx[X_W-1:0];
    y_d    = sy[Y_W-1:0];
    busy_d = state_d == PLOT;
    done_d = state_d == DONE;
    plot_d = busy_d && (!CLIP || (sx < (X_W+1)'(SCREEN_W) && sy < (Y_W+1)'(SCREEN_H)));
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bx_q     <= '0;
      by_q     <= '0;
      colour_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      colour_q <= colour_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      plot_q   <= plot_d;
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign plot       = plot_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = colour_q;
endmodule
